// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_GAP
  } state_t;

  // Default channel-ID header base; low 3 bits stay clear for the grant index.
  localparam logic [7:0] HDR_BASE_DEFAULT = 8'hA0;

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - round-robin first-set finder starting at a pointer
module rr_select #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any
);

  assign any = |req;

  // Scan from the far end down so the lowest offset from ptr wins.
  always_comb begin
    int c;
    c   = 0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      c = (int'(ptr) + k) % N;
      if (req[c]) idx = W'(c);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet round-robin arbiter in front of the UART TX byte path
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int         NUM_REQ       = 4,
  parameter int         MAX_PKT_BYTES = 64,
  parameter int         GAP_CYCLES    = 16,
  parameter logic [7:0] HDR_BASE      = HDR_BASE_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ*8-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 byte_out_data,
  output logic                       byte_out_valid,
  input  logic                       byte_out_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       trunc_pulse
);

  localparam int GW = $clog2(NUM_REQ);

  state_t         state, state_nxt;
  logic [GW-1:0]  rr_ptr;
  logic [GW-1:0]  sel_idx;
  logic           sel_any;
  logic [8:0]     byte_cnt;
  logic [15:0]    gap_cnt;
  logic           data_hs;
  logic           pkt_end;
  logic           at_max;

  rr_select #(.N(NUM_REQ), .W(GW)) u_rr_select (
    .req (req_valid),
    .ptr (rr_ptr),
    .idx (sel_idx),
    .any (sel_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  assign at_max = (byte_cnt == 9'(MAX_PKT_BYTES - 1));
  assign busy   = (state != ST_IDLE);

  always_comb begin
    state_nxt      = state;
    byte_out_valid = 1'b0;
    byte_out_data  = 8'h00;
    req_ready      = '0;
    trunc_pulse    = 1'b0;
    data_hs        = 1'b0;
    pkt_end        = 1'b0;
    case (state)
      ST_IDLE: if (sel_any) state_nxt = ST_HDR;
      ST_HDR: begin
        byte_out_valid = 1'b1;
        byte_out_data  = HDR_BASE | 8'(grant_id);
        if (byte_out_ready) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        // Pure pass-through: ready never looks at valid, so no comb loop.
        byte_out_valid      = req_valid[grant_id];
        byte_out_data       = req_data[8*int'(grant_id) +: 8];
        req_ready[grant_id] = byte_out_ready;
        data_hs             = req_valid[grant_id] & byte_out_ready;
        pkt_end             = data_hs & (req_last[grant_id] | at_max);
        trunc_pulse         = data_hs & at_max & ~req_last[grant_id];
        if (pkt_end) state_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
      end
      ST_GAP: if (gap_cnt == 16'(GAP_CYCLES - 1)) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id <= '0;
      rr_ptr   <= '0;
      byte_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      gap_cnt <= (state == ST_GAP) ? gap_cnt + 16'd1 : 16'd0;
      if (state == ST_IDLE && sel_any) begin
        grant_id <= sel_idx;
        byte_cnt <= '0;
      end
      if (data_hs) byte_cnt <= byte_cnt + 9'd1;
      if (pkt_end) rr_ptr <= (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a packet-level model
module tb_uart_tx_arbiter;

  localparam int NR   = 4;
  localparam int MAXB = 4;
  localparam int GAP  = 16;

  typedef struct {
    logic [7:0] data;
    logic       trunc;
    int         id;
    logic       end_pkt;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR*8-1:0] req_data = '0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_last = '0;
  logic [NR-1:0]   req_ready;
  logic [7:0]      byte_out_data;
  logic            byte_out_valid;
  logic            byte_out_ready = 1'b0;
  logic [1:0]      grant_id;
  logic            busy;
  logic            trunc_pulse;

  uart_tx_arbiter #(
    .NUM_REQ(NR), .MAX_PKT_BYTES(MAXB), .GAP_CYCLES(GAP), .HDR_BASE(8'hA0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_data(req_data), .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready),
    .byte_out_data(byte_out_data), .byte_out_valid(byte_out_valid), .byte_out_ready(byte_out_ready),
    .grant_id(grant_id), .busy(busy), .trunc_pulse(trunc_pulse)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] drv_q[NR][$];
  exp_t       exp_q[$];
  int         m_ptr = 0;
  bit         rnd_ready = 0;
  int         stall_left = 0;
  int         stall_req = 0;
  bit         stall_arm = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_pkt(input int r, input int len);
    for (int b = 0; b < len; b++)
      drv_q[r].push_back({(b == len - 1), 8'($urandom_range(0, 255))});
  endtask

  // Reference: every loaded requester stays valid, so grants follow plain round-robin over non-empty queues.
  task automatic model_push();
    logic [8:0] mq[NR][$];
    logic [8:0] b;
    int g, n;
    bit found;
    for (int i = 0; i < NR; i++) mq[i] = drv_q[i];
    forever begin
      found = 0;
      g = 0;
      for (int k = 0; k < NR; k++)
        if (!found && mq[(m_ptr + k) % NR].size() > 0) begin
          g = (m_ptr + k) % NR;
          found = 1;
        end
      if (!found) break;
      exp_q.push_back('{data: 8'hA0 + 8'(g), trunc: 1'b0, id: g, end_pkt: 1'b0});
      n = 0;
      do begin
        b = mq[g].pop_front();
        n++;
        exp_q.push_back('{data: b[7:0], trunc: (n == MAXB) && !b[8], id: g,
                          end_pkt: b[8] || (n == MAXB)});
      end while (!b[8] && n < MAXB);
      m_ptr = (g + 1) % NR;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (drv_q[i].size() > 0 && !(stall_left > 0 && i == stall_req)) begin
        req_valid[i]        = 1'b1;
        req_data[8*i +: 8]  = drv_q[i][0][7:0];
        req_last[i]         = drv_q[i][0][8];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[8*i +: 8]  = 8'h00;
        req_last[i]         = 1'b0;
      end
    end
    byte_out_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NR; i++) if (drv_q[i].size() > 0) return 0;
    return 1;
  endfunction

  task automatic run_phase(input string name, input int max_cyc, input bit do_stall, input bit do_reset);
    logic [NR-1:0] hs;
    int cyc;
    bit rst_done;
    rst_done  = 0;
    stall_arm = do_stall;
    drive();
    cyc = 0;
    while (cyc < max_cyc) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      if (stall_left > 0) begin
        chk("stall_grant", grant_id, stall_req);
        chk("stall_valid", byte_out_valid, 0);
      end
      if (!busy && exp_q.size() == 0 && all_empty()) break;
      @(posedge clk);
      #1;
      if (stall_left > 0) stall_left--;
      for (int i = 0; i < NR; i++)
        if (hs[i]) begin
          void'(drv_q[i].pop_front());
          if (stall_arm && drv_q[i].size() > 0) begin
            stall_arm  = 0;
            stall_req  = i;
            stall_left = 50;
          end
        end
      if (do_reset && !rst_done && drv_q[2].size() == 2) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", byte_out_valid, 0);
        chk("rst_async_data", byte_out_data, 0);
        chk("rst_async_ready", req_ready, 0);
        chk("rst_async_grant", grant_id, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_trunc", trunc_pulse, 0);
        for (int i = 0; i < NR; i++) drv_q[i].delete();
        exp_q.delete();
        m_ptr = 0;
        drive();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drv_q[1].push_back({1'b1, 8'h5A});
        drv_q[3].push_back({1'b1, 8'hC3});
        model_push();
        rst_done = 1;
      end
      drive();
      cyc++;
    end
    if (cyc >= max_cyc) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d cycles expected drain", name, cyc);
    end
  endtask

  bit gap_watch = 0;
  int gap_cnt = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) gap_watch = 0;
      else begin
        if (busy) chk("foreign_ready", req_ready & ~(4'b0001 << grant_id), 0);
        if (byte_out_valid && byte_out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h expected none", byte_out_data);
          end else begin
            e = exp_q.pop_front();
            chk("byte_data", byte_out_data, e.data);
            chk("trunc_pulse", trunc_pulse, e.trunc);
            chk("grant_id", grant_id, e.id);
            if (e.end_pkt) begin
              gap_watch = 1;
              gap_cnt = 0;
            end
          end
        end else if (gap_watch) begin
          if (busy) gap_cnt++;
          else begin
            chk("gap_len", gap_cnt, GAP);
            gap_watch = 0;
          end
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", byte_out_valid, 0);
    chk("reset_data", byte_out_data, 0);
    chk("reset_ready", req_ready, 0);
    chk("reset_grant", grant_id, 0);
    chk("reset_busy", busy, 0);
    chk("reset_trunc", trunc_pulse, 0);
    @(negedge clk);
    rst_n = 1'b1;

    drv_q[2].push_back({1'b0, 8'h11});
    drv_q[2].push_back({1'b0, 8'h22});
    drv_q[2].push_back({1'b1, 8'h33});
    model_push();
    run_phase("single", 200, 0, 0);

    for (int p = 0; p < 2; p++) begin
      add_pkt(0, 1);
      add_pkt(1, 1);
    end
    model_push();
    run_phase("round_robin", 400, 0, 0);

    add_pkt(3, 6);
    model_push();
    run_phase("truncation", 400, 0, 0);

    rnd_ready = 1;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NR; i++)
        if ($urandom_range(0, 1) == 1)
          for (int p = 0; p < int'($urandom_range(1, 2)); p++) add_pkt(i, $urandom_range(1, 6));
      model_push();
      run_phase("backpressure", 4000, 0, 0);
    end
    rnd_ready = 0;

    add_pkt(0, 3);
    add_pkt(1, 3);
    model_push();
    run_phase("stall", 600, 1, 0);

    add_pkt(2, 1);
    add_pkt(2, 3);
    model_push();
    run_phase("reset_mid", 600, 0, 1);

    chk("exp_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
